// File: rtl/RV32I_definitions.sv
// Shared RV32I pipeline definitions: fetch widths, bubble encoding and the
// instruction/PC pair carried through the fetch skid and IF/ID registers.
package RV32I_definitions;

   localparam int IMEM_ADDR_WIDTH = 10;
   localparam int INSTR_WIDTH     = 32;

   // addi x0,x0,0 -- the canonical pipeline bubble
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]                instr;
      logic [IMEM_ADDR_WIDTH-1:0] pc;
   } fetch_entry_t;

   // Pack an instruction with the PC it was fetched from
   function automatic fetch_entry_t make_entry(input logic [31:0]                instr,
                                               input logic [IMEM_ADDR_WIDTH-1:0] pc);
      fetch_entry_t e;
      e.instr = instr;
      e.pc    = pc;
      return e;
   endfunction

endpackage

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: drives the PC into synchronous IMEM, tracks the
// one outstanding read, and registers the returned instruction into IF/ID.
// A one-entry skid keeps a read that lands during a stall; a flush squashes
// the wrong-path read in flight and any skid contents.
module if_fetch_buffer #(
   parameter int          IMEM_ADDR_WIDTH = RV32I_definitions::IMEM_ADDR_WIDTH,
   parameter int          INSTR_WIDTH     = RV32I_definitions::INSTR_WIDTH,
   parameter logic [31:0] NOP_INSTR       = RV32I_definitions::NOP_INSTR
) (
   input  logic                       Clk,
   input  logic                       Reset_n,
   input  logic [IMEM_ADDR_WIDTH-1:0] PC_In,
   input  logic                       IF_Stall,
   input  logic                       IF_Flush,
   output logic [IMEM_ADDR_WIDTH-1:0] IMEM_Addr,
   output logic                       IMEM_Rd_En,
   input  logic [INSTR_WIDTH-1:0]     IMEM_Data,
   output logic [INSTR_WIDTH-1:0]     ID_Instr,
   output logic [IMEM_ADDR_WIDTH-1:0] ID_PC,
   output logic                       ID_Valid
);

   // The entry type fixes the instr/pc field widths to the package values.
   typedef RV32I_definitions::fetch_entry_t entry_t;

   logic                       pend_valid;
   logic [IMEM_ADDR_WIDTH-1:0] pend_pc;
   logic                       skid_valid;
   entry_t                     skid;
   entry_t                     id_entry;
   logic                       id_valid;

   // IMEM is driven straight from the PC; a stalled PC issues no read, which
   // is what keeps the skid and an outstanding read from coexisting.
   assign IMEM_Addr  = PC_In;
   assign IMEM_Rd_En = ~IF_Stall;

   assign ID_Instr = id_entry.instr;
   assign ID_PC    = id_entry.pc;
   assign ID_Valid = id_valid;

   // Outstanding-read tracking, skid buffer and IF/ID register
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pend_valid <= 1'b0;
         pend_pc    <= '0;
         skid_valid <= 1'b0;
         skid       <= RV32I_definitions::make_entry(NOP_INSTR, '0);
         id_entry   <= RV32I_definitions::make_entry(NOP_INSTR, '0);
         id_valid   <= 1'b0;
      end else begin
         // A redirect squashes the read issued this cycle, unless the stall
         // already blocks both the read and the redirect.
         pend_valid <= IMEM_Rd_En & ~(IF_Flush & ~IF_Stall);
         pend_pc    <= PC_In;

         if (IF_Stall) begin
            // ID holds; a read landing now is parked in the skid
            if (pend_valid) begin
               skid       <= RV32I_definitions::make_entry(IMEM_Data, pend_pc);
               skid_valid <= 1'b1;
            end
         end else if (IF_Flush) begin
            // Wrong path: bubble into ID, drop skid and returning data
            id_entry   <= RV32I_definitions::make_entry(NOP_INSTR, id_entry.pc);
            id_valid   <= 1'b0;
            skid_valid <= 1'b0;
         end else if (skid_valid) begin
            // Drain the parked instruction first to keep program order
            id_entry   <= skid;
            id_valid   <= 1'b1;
            skid_valid <= 1'b0;
         end else if (pend_valid) begin
            id_entry <= RV32I_definitions::make_entry(IMEM_Data, pend_pc);
            id_valid <= 1'b1;
         end else begin
            // Nothing arrived: bubble, PC keeps its last value
            id_entry <= RV32I_definitions::make_entry(NOP_INSTR, id_entry.pc);
            id_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Bench for if_fetch_buffer: a PC register and synchronous IMEM around the
// DUT, a queue model of in-order fetch delivery checked every cycle, and
// directed checks with hand-derived expectations.
module tb_if_fetch_buffer;

   localparam int          AW  = 10;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic          Clk;
   logic          Reset_n;
   logic [AW-1:0] pc_reg;
   logic          IF_Stall;
   logic          IF_Flush;
   logic [AW-1:0] IMEM_Addr;
   logic          IMEM_Rd_En;
   logic [31:0]   IMEM_Data;
   logic [31:0]   ID_Instr;
   logic [AW-1:0] ID_PC;
   logic          ID_Valid;

   logic [AW-1:0] target;
   int            errors;
   int            checks;
   int            cyc;

   // Model state: fetches accepted but not yet delivered to ID
   logic [AW-1:0] fetch_q[$];
   logic          exp_valid;
   logic [31:0]   exp_instr;
   logic [AW-1:0] exp_pc;

   if_fetch_buffer dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .PC_In      (pc_reg),
      .IF_Stall   (IF_Stall),
      .IF_Flush   (IF_Flush),
      .IMEM_Addr  (IMEM_Addr),
      .IMEM_Rd_En (IMEM_Rd_En),
      .IMEM_Data  (IMEM_Data),
      .ID_Instr   (ID_Instr),
      .ID_PC      (ID_PC),
      .ID_Valid   (ID_Valid)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // PC register: stall beats redirect, otherwise sequential
   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)      pc_reg <= '0;
      else if (IF_Stall) pc_reg <= pc_reg;
      else if (IF_Flush) pc_reg <= target;
      else               pc_reg <= pc_reg + 1'b1;
   end

   // Synchronous IMEM with IMEM[k] = 0x100 + k
   always @(posedge Clk) begin
      if (IMEM_Rd_En) IMEM_Data <= 32'h100 + {22'd0, IMEM_Addr};
   end

   // Delivery model: every unstalled, unflushed cycle accepts the current PC
   // and hands the oldest accepted fetch to ID; a flush discards all
   // accepted fetches; a stall freezes everything.
   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         fetch_q.delete();
         exp_valid <= 1'b0;
         exp_instr <= NOP;
         exp_pc    <= '0;
      end else if (IF_Stall) begin
         exp_valid <= exp_valid;
      end else if (IF_Flush) begin
         fetch_q.delete();
         exp_valid <= 1'b0;
         exp_instr <= NOP;
      end else begin
         if (fetch_q.size() > 0) begin
            exp_valid <= 1'b1;
            exp_pc    <= fetch_q[0];
            exp_instr <= 32'h100 + {22'd0, fetch_q[0]};
            void'(fetch_q.pop_front());
         end else begin
            exp_valid <= 1'b0;
            exp_instr <= NOP;
         end
         fetch_q.push_back(pc_reg);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Per-cycle comparison against the model, sampled mid-cycle
   always @(negedge Clk) begin
      if (Reset_n) begin
         chk("model_valid", {31'd0, ID_Valid}, {31'd0, exp_valid});
         chk("model_instr", ID_Instr, exp_instr);
         if (exp_valid) chk("model_pc", {22'd0, ID_PC}, {22'd0, exp_pc});
         chk("imem_addr", {22'd0, IMEM_Addr}, {22'd0, pc_reg});
         chk("imem_rd_en", {31'd0, IMEM_Rd_En}, {31'd0, ~IF_Stall});
         chk("skid_pend_excl", {31'd0, dut.skid_valid & dut.pend_valid}, 32'd0);
         if (ID_Valid) $display("cyc %0d ID pc=%h instr=%h", cyc, ID_PC, ID_Instr);
      end
   end

   // Advance to the next cycle and apply its controls
   task automatic step(input logic s, input logic f);
      @(posedge Clk);
      #2;
      cyc      = cyc + 1;
      IF_Stall = s;
      IF_Flush = f;
   endtask

   task automatic expect_id(input string name, input logic v, input logic [AW-1:0] pc,
                            input logic [31:0] instr);
      @(negedge Clk);
      #1;
      chk({name, "_valid"}, {31'd0, ID_Valid}, {31'd0, v});
      chk({name, "_instr"}, ID_Instr, instr);
      if (v) chk({name, "_pc"}, {22'd0, ID_PC}, {22'd0, pc});
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      cyc      = 0;
      Reset_n  = 1'b0;
      IF_Stall = 1'b0;
      IF_Flush = 1'b0;
      target   = '0;

      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("rst_valid", {31'd0, ID_Valid}, 32'd0);
      chk("rst_instr", ID_Instr, NOP);
      chk("rst_pc", {22'd0, ID_PC}, 32'd0);

      // Cycle 0 is the first cycle out of reset
      @(posedge Clk);
      #2;
      Reset_n = 1'b1;
      cyc     = 0;
      expect_id("c0", 1'b0, 10'd0, NOP);
      step(0, 0); expect_id("c1", 1'b0, 10'd0, NOP);
      step(0, 0); expect_id("c2", 1'b1, 10'd0, 32'h100);
      step(0, 0); expect_id("c3", 1'b1, 10'd1, 32'h101);
      step(0, 0);
      step(0, 0);

      // Stall while PC 5 data returns; ID frozen at PC 4
      step(1, 0); expect_id("stall_c6", 1'b1, 10'd4, 32'h104);
      chk("stall_rd_en", {31'd0, IMEM_Rd_En}, 32'd0);
      step(1, 0);
      step(1, 0); expect_id("stall_c8", 1'b1, 10'd4, 32'h104);
      chk("stall_skid", {31'd0, dut.skid_valid}, 32'd1);
      step(0, 0); expect_id("rel_c9", 1'b1, 10'd4, 32'h104);
      step(0, 0); expect_id("rel_c10", 1'b1, 10'd5, 32'h105);
      step(0, 0); expect_id("rel_c11", 1'b1, 10'd6, 32'h106);

      // Redirect to 0x20 while ID holds PC 7 and PC 8 is in flight
      target = 10'h020;
      step(0, 1); expect_id("fl_c12", 1'b1, 10'd7, 32'h107);
      step(0, 0); expect_id("fl_bub1", 1'b0, 10'd0, NOP);
      step(0, 0); expect_id("fl_bub2", 1'b0, 10'd0, NOP);
      step(0, 0); expect_id("fl_tgt", 1'b1, 10'h020, 32'h120);
      step(0, 0);

      // Stall and flush together: flush ignored, sequence resumes
      target = 10'h200;
      step(1, 1); expect_id("sf_c17", 1'b1, 10'h022, 32'h122);
      step(1, 1);
      step(0, 0); expect_id("sf_c19", 1'b1, 10'h022, 32'h122);
      step(0, 0); expect_id("sf_c20", 1'b1, 10'h023, 32'h123);
      step(0, 0); expect_id("sf_c21", 1'b1, 10'h024, 32'h124);

      // Reset mid-stall with the skid full
      step(1, 0);
      step(1, 0);
      @(negedge Clk);
      #1;
      chk("pre_rst_skid", {31'd0, dut.skid_valid}, 32'd1);
      Reset_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, ID_Valid}, 32'd0);
      chk("arst_instr", ID_Instr, NOP);
      chk("arst_pc", {22'd0, ID_PC}, 32'd0);
      chk("arst_skid", {31'd0, dut.skid_valid}, 32'd0);
      @(posedge Clk);
      #2;
      IF_Stall = 1'b0;
      Reset_n  = 1'b1;
      cyc      = 0;
      step(0, 0);
      step(0, 0); expect_id("refetch_c2", 1'b1, 10'd0, 32'h100);

      // Random stall/flush stress, checked by the per-cycle model compare
      for (int i = 0; i < 400; i++) begin
         target = AW'($urandom_range(0, 1023));
         step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 12));
      end
      repeat (4) step(0, 0);
      @(negedge Clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
